// File: rtl/yuv420_frame_parser.sv
// Planar YUV 4:2:0 byte-stream parser: tags each byte with plane/column/row plus sof/eol/eof.
// Latency: 1 clk from accepted byte to pix_* outputs.
// Backpressure: none; every data_valid byte is taken, idle cycles freeze all state.
// Optional feature macro: YUV_CHECKSUM_EN adds frame_sum (mod-2^16 byte sum of each frame).
module yuv420_frame_parser #(
  parameter int WIDTH  = 352,
  parameter int HEIGHT = 288,
  parameter int XW     = 9,
  parameter int YW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    data,
  input  logic          data_valid,
  input  logic          flush,
  output logic [7:0]    pix_data,
  output logic          pix_valid,
  output logic [1:0]    plane,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          sof,
  output logic          eol,
  output logic          eof,
`ifdef YUV_CHECKSUM_EN
  output logic [15:0]   frame_sum,
`endif
  output logic [15:0]   frame_cnt
);

  localparam logic [1:0] S_Y = 2'd0;
  localparam logic [1:0] S_U = 2'd1;
  localparam logic [1:0] S_V = 2'd2;

  localparam logic [XW-1:0] X_LAST_Y = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X_LAST_C = XW'(WIDTH / 2 - 1);
  localparam logic [YW-1:0] Y_LAST_Y = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_LAST_C = YW'(HEIGHT / 2 - 1);

  logic [1:0]    r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [15:0]   r_frame_cnt;
  logic [7:0]    r_pix_data;
  logic          r_pix_valid;
  logic [1:0]    r_plane;
  logic [XW-1:0] r_pix_x;
  logic [YW-1:0] r_pix_y;
  logic          r_sof;
  logic          r_eol;
  logic          r_eof;

  // A flush in the same cycle as a byte makes that byte Y(0,0) of a new frame,
  // so the tagging position is the flushed one, not the stored one.
  logic [1:0]    w_state;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [XW-1:0] w_x_last;
  logic [YW-1:0] w_y_last;
  logic          w_eol;
  logic          w_last_row;
  logic          w_sof;
  logic          w_eof;
  logic [1:0]    w_next_plane;

  // Effective position and plane bounds for the byte presented this cycle
  always_comb begin
    w_state      = flush ? S_Y : r_state;
    w_x          = flush ? '0 : r_x;
    w_y          = flush ? '0 : r_y;
    w_x_last     = (w_state == S_Y) ? X_LAST_Y : X_LAST_C;
    w_y_last     = (w_state == S_Y) ? Y_LAST_Y : Y_LAST_C;
    w_eol        = (w_x == w_x_last);
    w_last_row   = (w_y == w_y_last);
    w_sof        = (w_state == S_Y) && (w_x == '0) && (w_y == '0);
    w_eof        = (w_state == S_V) && w_eol && w_last_row;
    w_next_plane = S_Y;
    case (w_state)
      S_Y:     w_next_plane = S_U;
      S_U:     w_next_plane = S_V;
      default: w_next_plane = S_Y;
    endcase
  end

  // Column/row counters and plane FSM; advance only on accepted bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_Y;
      r_x     <= '0;
      r_y     <= '0;
    end else if (data_valid) begin
      r_x     <= w_eol ? '0 : w_x + XW'(1);
      r_y     <= w_eol ? (w_last_row ? '0 : w_y + YW'(1)) : w_y;
      r_state <= (w_eol && w_last_row) ? w_next_plane : w_state;
    end else if (flush) begin
      r_state <= S_Y;
      r_x     <= '0;
      r_y     <= '0;
    end
  end

  // Output register: tags hold across gaps, markers are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_plane     <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_pix_valid <= data_valid;
      r_sof       <= data_valid && w_sof;
      r_eol       <= data_valid && w_eol;
      r_eof       <= data_valid && w_eof;
      if (data_valid) begin
        r_pix_data <= data;
        r_plane    <= w_state;
        r_pix_x    <= w_x;
        r_pix_y    <= w_y;
        if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign plane     = r_plane;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign sof       = r_sof;
  assign eol       = r_eol;
  assign eof       = r_eof;
  assign frame_cnt = r_frame_cnt;

`ifdef YUV_CHECKSUM_EN
  logic [15:0] r_acc;
  logic [15:0] r_frame_sum;
  logic [15:0] w_acc_base;
  logic [15:0] w_acc_next;

  // Sum restarts with the first byte of every frame (sof or flushed byte)
  always_comb begin
    w_acc_base = (flush || w_sof) ? 16'd0 : r_acc;
    w_acc_next = w_acc_base + {8'd0, data};
  end

  // Running accumulator; the final total is captured alongside eof
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_frame_sum <= '0;
    end else if (data_valid) begin
      r_acc <= w_acc_next;
      if (w_eof) r_frame_sum <= w_acc_next;
    end else if (flush) begin
      r_acc <= '0;
    end
  end

  assign frame_sum = r_frame_sum;
`endif

endmodule

// File: tb/tb_yuv420_frame_parser.sv
// Self-checking bench for yuv420_frame_parser at WIDTH=4, HEIGHT=2.
// Stimulus is a linear directed sequence; a reference model pushes expected tags to a queue.
// A negedge monitor pops and compares every output byte; idle cycles must carry no markers.
module tb_yuv420_frame_parser;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int XW = 2;
  localparam int YW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'd0;
  logic          data_valid = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic [1:0]    plane;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          sof;
  logic          eol;
  logic          eof;
  logic [15:0]   frame_cnt;
`ifdef YUV_CHECKSUM_EN
  logic [15:0]   frame_sum;
`endif

  yuv420_frame_parser #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .flush      (flush),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .plane      (plane),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
`ifdef YUV_CHECKSUM_EN
    .frame_sum  (frame_sum),
`endif
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    d;
    logic [1:0]    p;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
  } exp_t;

  exp_t q[$];
  int total  = 0;
  int passed = 0;
  int n_sof  = 0;
  int n_eof  = 0;
  int ms = 0, mx = 0, my = 0;
  logic [15:0] mfc   = 16'd0;
  logic [15:0] msum  = 16'd0;
  logic [15:0] mfsum = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: compare each output byte against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pix_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_byte", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pix_data", 32'(pix_data), 32'(e.d));
          chk("plane",    32'(plane),    32'(e.p));
          chk("pix_x",    32'(pix_x),    32'(e.x));
          chk("pix_y",    32'(pix_y),    32'(e.y));
          chk("sof",      32'(sof),      32'(e.sof));
          chk("eol",      32'(eol),      32'(e.eol));
          chk("eof",      32'(eof),      32'(e.eof));
          if (sof) n_sof++;
          if (eof) n_eof++;
        end
      end else begin
        chk("idle_markers", 32'({sof, eol, eof}), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: tags the byte, advances position, then drives it for one edge
  task automatic send(input logic [7:0] d, input logic f);
    exp_t e;
    int pw, ph;
    if (f) begin
      ms = 0; mx = 0; my = 0;
    end
    pw = (ms == 0) ? W : W / 2;
    ph = (ms == 0) ? H : H / 2;
    e.d   = d;
    e.p   = ms[1:0];
    e.x   = mx[XW-1:0];
    e.y   = my[YW-1:0];
    e.sof = (ms == 0) && (mx == 0) && (my == 0);
    e.eol = (mx == pw - 1);
    e.eof = (ms == 2) && (mx == pw - 1) && (my == ph - 1);
    if (e.sof) msum = 16'd0;
    msum = msum + 16'(d);
    if (e.eof) begin
      mfc   = mfc + 16'd1;
      mfsum = msum;
    end
    q.push_back(e);
    if (mx == pw - 1) begin
      mx = 0;
      if (my == ph - 1) begin
        my = 0;
        ms = (ms + 1) % 3;
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    data       = d;
    data_valid = 1'b1;
    flush      = f;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic frame(input int gap);
    for (int i = 0; i < 12; i++) begin
      send(8'(i), 1'b0);
      idle(gap);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_data"},  32'(pix_data),  32'd0);
    chk({tag, "_plane"},     32'(plane),     32'd0);
    chk({tag, "_xy"},        32'({pix_x, pix_y}), 32'd0);
    chk({tag, "_markers"},   32'({sof, eol, eof}), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
`ifdef YUV_CHECKSUM_EN
    chk({tag, "_frame_sum"}, 32'(frame_sum), 32'd0);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    ms = 0; mx = 0; my = 0;
    mfc = 16'd0; msum = 16'd0; mfsum = 16'd0;
    q.delete();
    @(posedge clk);
    #1;
    check_zero_outputs(tag);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    idle(2);
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int s0, e0;
    // Test 1: reset then one back-to-back frame
    do_reset("reset");
    frame(0);
    chk("t1_frame_cnt", 32'(frame_cnt), 32'(mfc));
    chk("t1_frame_cnt_const", 32'(frame_cnt), 32'd1);
    drain("t1");
    // Test 2: one idle cycle after every byte
    s0 = n_sof; e0 = n_eof;
    frame(1);
    drain("t2");
    chk("t2_sof_pulses", 32'(n_sof - s0), 32'd1);
    chk("t2_eof_pulses", 32'(n_eof - e0), 32'd1);
    chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
    // Test 3: flush with a byte in the same cycle
    do_reset("t3_reset");
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
    send(8'hAA, 1'b1);
    for (int i = 1; i < 12; i++) send(8'(i), 1'b0);
    chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    drain("t3");
    // Test 4: reset mid-frame discards the partial frame
    for (int i = 0; i < 7; i++) send(8'(8'h20 + i), 1'b0);
    idle(1);
    do_reset("t4_midreset");
    frame(0);
    chk("t4_frame_cnt", 32'(frame_cnt), 32'd1);
    drain("t4");
    // Test 5: three frames, then frame counter wrap
    do_reset("t5_reset");
    s0 = n_sof; e0 = n_eof;
    frame(0);
    frame(2);
    frame(0);
    drain("t5");
    chk("t5_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("t5_sof_pulses", 32'(n_sof - s0), 32'd3);
    chk("t5_eof_pulses", 32'(n_eof - e0), 32'd3);
    force dut.r_frame_cnt = 16'hFFFF;
    idle(1);
    release dut.r_frame_cnt;
    idle(1);
    chk("t5_preset", 32'(frame_cnt), 32'hFFFF);
    mfc = 16'hFFFF;
    frame(0);
    chk("t5_wrap", 32'(frame_cnt), 32'(mfc));
    chk("t5_wrap_const", 32'(frame_cnt), 32'h0000);
    drain("t5_wrap");
`ifdef YUV_CHECKSUM_EN
    // Test 6: per-frame checksum
    do_reset("t6_reset");
    for (int i = 0; i < 12; i++) send(8'hFF, 1'b0);
    chk("t6_sum_ff", 32'(frame_sum), 32'h0BF4);
    chk("t6_sum_ff_model", 32'(frame_sum), 32'(mfsum));
    idle(3);
    chk("t6_sum_hold", 32'(frame_sum), 32'h0BF4);
    for (int i = 0; i < 12; i++) send(8'h01, 1'b0);
    chk("t6_sum_01", 32'(frame_sum), 32'h000C);
    drain("t6");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
